// File: rtl/spatz_cache_pkg.sv
// Shared types and limits for the Spatz cache response demux.
package spatz_cache_pkg;

    typedef logic cache_port_id_t;

    localparam int unsigned CacheDemuxMaxDepth = 16;

endpackage

// File: rtl/spatz_cache_demux_spill.sv
// Two-entry valid/ready spill register: one-cycle latency, full throughput,
// and ready_o depends only on local state.
module spatz_cache_demux_spill #(
    parameter type DATA_T = logic
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  valid_i,
    output logic  ready_o,
    input  DATA_T data_i,
    output logic  valid_o,
    input  logic  ready_i,
    output DATA_T data_o
);

    logic  a_full_q, b_full_q;
    DATA_T a_data_q, b_data_q;
    logic  a_fill, a_drain, b_fill, b_drain;

    // A is the input stage; B only fills when A must move on while downstream stalls.
    assign a_fill  = valid_i && ready_o;
    assign a_drain = a_full_q && !b_full_q;
    assign b_fill  = a_drain && !ready_i;
    assign b_drain = b_full_q && ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_full_q <= 1'b0;
            b_full_q <= 1'b0;
            a_data_q <= '0;
            b_data_q <= '0;
        end else begin
            if (a_fill) begin
                a_data_q <= data_i;
            end
            if (a_fill || a_drain) begin
                a_full_q <= a_fill;
            end
            if (b_fill) begin
                b_data_q <= a_data_q;
            end
            if (b_fill || b_drain) begin
                b_full_q <= b_fill;
            end
        end
    end

    assign ready_o = !a_full_q || !b_full_q;
    assign valid_o = a_full_q || b_full_q;
    assign data_o  = b_full_q ? b_data_q : a_data_q;

endmodule

// File: rtl/spatz_cache_demux.sv
// Response-side 1-to-2 router: records the winning port of each accepted request
// and steers in-order responses back to it. Define SPATZ_CACHE_DEMUX_SPILL_EN to
// register each output port through spatz_cache_demux_spill.
module spatz_cache_demux
    import spatz_cache_pkg::*;
#(
    parameter type         DATA_T = logic,
    parameter int unsigned Depth  = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic        req_ready_i,
    input  logic        req_port_i,
    output logic        req_full_o,
    input  DATA_T       rsp_data_i,
    input  logic        rsp_valid_i,
    output logic        rsp_ready_o,
    output DATA_T [1:0] oup_data_o,
    output logic [1:0]  oup_valid_o,
    input  logic [1:0]  oup_ready_i,
    output logic        err_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    if (Depth > CacheDemuxMaxDepth) begin : gen_depth_max_chk
        $error("spatz_cache_demux: Depth exceeds CacheDemuxMaxDepth");
    end
    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : gen_depth_pow2_chk
        $error("spatz_cache_demux: Depth must be a power of two and at least 2");
    end

    cache_port_id_t  order_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            err_q;

    cache_port_id_t  head;
    logic            empty, push, pop;

    assign empty      = (cnt_q == '0);
    assign head       = order_q[rd_ptr_q];
    assign req_full_o = (cnt_q == CntW'(Depth));
    assign push       = req_valid_i && req_ready_i && !req_full_o;
    assign pop        = rsp_valid_i && rsp_ready_o && !empty;
    assign err_o      = err_q;

    // A push never reaches the head in the same cycle, so a response arriving
    // on an empty queue is always spurious regardless of a concurrent push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            order_q  <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                order_q[wr_ptr_q] <= req_port_i;
                wr_ptr_q          <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CntW'(1);
            end
            if (rsp_valid_i && empty) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef SPATZ_CACHE_DEMUX_SPILL_EN
    logic [1:0] spill_valid, spill_ready;

    always_comb begin
        spill_valid = '0;
        if (!empty) begin
            spill_valid[head] = rsp_valid_i;
        end
    end

    // Spurious responses are still sunk immediately so the controller never stalls.
    assign rsp_ready_o = empty ? rsp_valid_i : spill_ready[head];

    for (genvar p = 0; p < 2; p++) begin : gen_spill
        spatz_cache_demux_spill #(
            .DATA_T (DATA_T)
        ) i_spill (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .valid_i (spill_valid[p]),
            .ready_o (spill_ready[p]),
            .data_i  (rsp_data_i),
            .valid_o (oup_valid_o[p]),
            .ready_i (oup_ready_i[p]),
            .data_o  (oup_data_o[p])
        );
    end
`else
    always_comb begin
        oup_valid_o = '0;
        if (!empty) begin
            oup_valid_o[head] = rsp_valid_i;
        end
    end

    assign oup_data_o[0] = rsp_data_i;
    assign oup_data_o[1] = rsp_data_i;
    assign rsp_ready_o   = empty ? rsp_valid_i : oup_ready_i[head];
`endif

endmodule

// File: doc/spatz_cache_demux.md
# spatz_cache_demux

Response-side 1-to-2 router for the Spatz cache interconnect. It sits beside the 2-to-1 request mux that feeds one cache-controller port. It records which input port won each accepted request. It then steers the in-order responses returning from the cache controller back to the originating port. An outstanding-request counter bounds in-flight traffic and raises a stall toward the request side when the order queue fills.

## Interface
- `DATA_T`, default `logic`: response payload type, passed through unmodified.
- `Depth`, default 4: maximum outstanding requests. Must be a power of two, ≥2.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_valid_i`  in  1  valid on the request mux output.
- `req_ready_i`  in  1  ready on the request mux output, as seen by the cache controller.
- `req_port_i`  in  1  port index selected by the request mux this cycle.
- `req_full_o`  out  1  order queue full; the integrator ANDs its inverse into the request-side ready.
- `rsp_data_i`  in  DATA_T  response from the cache controller.
- `rsp_valid_i`  in  1  response valid.
- `rsp_ready_o`  out  1  response ready.
- `oup_data_o`  out  DATA_T [1:0]  per-port response data.
- `oup_valid_o`  out  [1:0]  per-port response valid.
- `oup_ready_i`  in  [1:0]  per-port response ready.
- `err_o`  out  1  sticky flag set by a response arriving with no request outstanding.

## Operation
- Order queue: a FIFO of 1-bit port IDs, `Depth` entries, with pointers `$clog2(Depth)` wide that wrap modulo `Depth`.
  - Occupancy counter `cnt_q` is `$clog2(Depth+1)` bits wide.
- Push occurs when `req_valid_i && req_ready_i && !req_full_o`. It writes `req_port_i`.
  - A push attempted while full is ignored. The request side must not see a handshake while `req_full_o` is high.
- Pop occurs when `rsp_valid_i && rsp_ready_o && cnt_q != 0`.
- Routing:
  - Head entry `h` selects the output port.
  - `oup_valid_o[h] = rsp_valid_i`.
  - `oup_valid_o[!h] = 0`.
  - `oup_data_o[0]` and `oup_data_o[1]` both carry `rsp_data_i`.
  - `rsp_ready_o = oup_ready_i[h]`.
- Empty queue with a response valid:
  - `rsp_ready_o = 1`, the response is dropped, both valids stay 0.
  - `err_o` sets and holds until reset.
  - A push in the same cycle does not bypass: a response never corresponds to a request accepted in the same cycle.
- Simultaneous push and pop: the counter is unchanged and both pointers advance.
- Full: `req_full_o = (cnt_q == Depth)`, driven from registers only. A pop while full deasserts `req_full_o` in the next cycle.
- Reset mid-operation clears the pointers, the counter and `err_o`. In-flight responses arriving after reset are treated as spurious and set `err_o`.

## Timing
- Reset values:
  - `req_full_o = 0`, `rsp_ready_o = 0` (the queue is empty and no response is pending).
  - `oup_valid_o = 2'b00`, `err_o = 0`, `oup_data_o` undefined.
- Default build: zero-cycle response path, combinational from `rsp_*` and `oup_ready_i` to outputs. The queue update is visible the next cycle.
- Valid/ready rules:
  - Once `oup_valid_o[h]` is high, the head cannot change until the handshake completes.
  - Data stability is inherited from the cache controller's valid/ready contract.
- Throughput: one response per cycle.

## Configuration
- `SPATZ_CACHE_DEMUX_SPILL_EN` defined: inserts one `spatz_cache_demux_spill` register per output port.
  - Response latency becomes 1 cycle.
  - Full throughput is kept: two-entry spill, one response per cycle.
  - `rsp_ready_o` no longer depends combinationally on `oup_ready_i`.
  - Pop occurs when the response enters the spill register.
- Macro undefined: purely combinational path, as described under Timing.

## Structure
- `spatz_cache_pkg` holds:
  - `cache_port_id_t` (1-bit).
  - The localparam `CacheDemuxMaxDepth = 16`, with a static assertion `Depth <= CacheDemuxMaxDepth`.
- Sub-module `spatz_cache_demux_spill`: a generic two-entry valid/ready spill register parameterized on `DATA_T`. It is instantiated only under the macro.
- The order FIFO stays inline (pointer and counter logic); no separate module.

## Test plan
- Single request then response, in both builds:
  - Push port 1 with `rsp_data=0xA5`, then the response arrives.
  - Expect `oup_valid_o=2'b10`, `oup_data_o[1]=0xA5`, `cnt` back to 0.
  - Latency is 0 cycles by default and 1 cycle with the macro.
- Interleaved order: push ports 0,1,1,0, then 4 back-to-back responses D0..D3.
  - Port 0 receives D0 and D3; port 1 receives D1 and D2, in order.
  - `req_full_o` is high after the 4th push (`Depth=4`).
- Back-pressure: head is port 0 with `oup_ready_i[0]=0` for 3 cycles.
  - `rsp_ready_o=0`, data held, no pop.
  - The response completes on the cycle ready rises.
- Full boundary: 4 pushes, then a push attempt alongside a pop in the same cycle.
  - The extra push is ignored and `cnt=3`.
  - `req_full_o` deasserts the next cycle.
- Spurious response: with the queue empty, drive `rsp_valid_i=1`.
  - Expect `rsp_ready_o=1`, `oup_valid_o=0`, `err_o=1` held.
  - After an asynchronous reset pulse, `err_o=0`, `cnt=0`.
- Pointer wrap: 10 push/pop pairs with random port IDs.
  - All responses route to the recorded port.
  - Simultaneous push and pop cycles keep `cnt` constant.
